lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit between the pipeline's memory stage and the byte-addressable data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, data, enable and funct3 inputs. Aligned accesses take one memory cycle. Misaligned halfword/word accesses are split into sequential byte accesses, with load bytes reassembled and extended. Returns one registered response per request.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width (fixed at 32 for this design)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- req_addr_i  in  AWIDTH  byte address
- req_data_i  in  DWIDTH  store data (low bytes used for SB/SH)
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RISC-V load/store funct3
- resp_valid_o  out  1  one-cycle response strobe
- resp_data_o  out  DWIDTH  load result; 0 for stores and errors
- resp_misaligned_o  out  1  request was split into byte beats
- resp_err_o  out  1  illegal funct3; no memory access performed
- mem_addr_o  out  AWIDTH  to memory addr_i
- mem_data_o  out  DWIDTH  to memory data_i
- mem_read_en_o  out  1  to memory read_en_i
- mem_write_en_o  out  1  to memory write_en_i
- mem_funct3_o  out  3  to memory funct3_i
- mem_data_i  in  DWIDTH  from memory data_o (combinational read)

## Operation
- **States:** IDLE, ACCESS, SPLIT, RESP.
- **Handshake:** req_ready_o = (state == IDLE) and not rst. A request is accepted on a clock edge where req_valid_i and req_ready_o are both 1. On acceptance, addr, data, we and funct3 are latched; later changes to req_* are ignored.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else goes IDLE→RESP with resp_err_o = 1 and no memory enables asserted.
- **Alignment:**
  - Byte accesses are always aligned.
  - LH/LHU/SH are aligned iff addr[0] == 0.
  - LW/SW are aligned iff addr[1:0] == 0.
- **Aligned access:** IDLE→ACCESS→RESP.
  - In ACCESS, drive mem_addr_o = latched addr and mem_funct3_o = latched funct3.
  - Load: mem_read_en_o = 1; capture mem_data_i, already extended by memory, into the result register at the end of ACCESS.
  - Store: mem_write_en_o = 1 and mem_data_o = latched data.
- **Misaligned access:** IDLE→SPLIT→RESP, N = 2 (halfword) or 4 (word) beats, 2-bit beat counter starting at 0.
  - Beat k drives mem_addr_o = addr + k (modulo 2^AWIDTH, wraps).
  - Load beat: mem_funct3_o = 100 (LBU) and mem_read_en_o = 1. Result byte k is loaded from mem_data_i[7:0].
  - Store beat: mem_funct3_o = 000 (SB), mem_write_en_o = 1, and mem_data_o = latched data >> 8k.
  - Leave SPLIT after beat N-1.
  - Final extension of the assembled result: LH sign-extends from bit 15, LHU zero-extends from bit 15, LW is unchanged.
- **RESP:** resp_valid_o = 1 for exactly one cycle, then return to IDLE.
  - resp_data_o, resp_misaligned_o and resp_err_o are registered and valid only while resp_valid_o = 1.
  - All three are 0 otherwise.
- **Memory outputs outside ACCESS/SPLIT:** mem_read_en_o = mem_write_en_o = 0, and mem_addr_o, mem_data_o, mem_funct3_o = 0.
- **Out-of-range addresses:** no range checks in this unit. Memory error data (0xDEADBEEF, or its low byte per beat) is passed through as the result.

## Timing
- **Reset values:** state IDLE, beat counter 0, result register 0. All resp_* = 0 and all mem_* = 0. req_ready_o = 0 while rst is high and 1 on the first cycle after release.
- **Latency, counted from the acceptance edge (edge 0):**
  - Aligned: resp_valid_o high in cycle 2.
  - Misaligned halfword: resp_valid_o high in cycle 3.
  - Misaligned word: resp_valid_o high in cycle 5.
  - Illegal funct3: resp_valid_o high in cycle 1.
- **Store commit:** memory commits a store on the edge that ends each write-enabled cycle.
- **Throughput:** a new request can be accepted in the cycle after RESP (IDLE). There is no overlap: req_ready_o = 0 in ACCESS, SPLIT and RESP.
- **Reset mid-operation:**
  - rst forces IDLE immediately (asynchronously) and all enables drop in the same cycle.
  - No response is produced.
  - Bytes already written by completed beats stay written; no rollback.
- **Address wrap:** addr 0xFFFFFFFF with a misaligned LH uses beats at 0xFFFFFFFF and 0x00000000.

## Test plan
- Aligned LW @0x01000000 with memory word 0x12345678 → mem_read_en_o high in cycle 1 only. resp_valid_o in cycle 2 with data 0x12345678, misaligned 0, err 0.
- SW 0xAABBCCDD @0x01000005 → four SPLIT beats at addr 0x01000005..0x01000008, funct3 000, data low bytes DD, CC, BB, AA, resp in cycle 5. A following LW @0x01000005 returns 0xAABBCCDD with misaligned 1.
- Bytes 0x80 @0x01000003 and 0xFF @0x01000004, then LH @0x01000003 → 0xFFFFFF80. LHU at the same address → 0x0000FF80. Both take two beats with resp in cycle 3.
- req_funct3_i = 011 load → resp_valid_o in cycle 1 with err 1, data 0. mem_read_en_o and mem_write_en_o never assert.
- req_valid_i held high for two back-to-back aligned SWs → req_ready_o low for cycles 1–2. Second request accepted on edge 3; exactly two write-enable pulses.
- rst asserted during beat 2 of a misaligned SW → enables drop the same cycle and no resp_valid_o. Only beats 0–1 are written in memory, and req_ready_o = 1 one cycle after rst release.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store control unit between the memory pipeline stage and a
// byte-addressable data memory.
//
// Accepts one load/store at a time over a valid/ready handshake. Aligned
// accesses use one memory cycle. Misaligned halfword/word accesses are split
// into byte beats (LBU/SB), and load bytes are reassembled and extended here.
// Every request gets exactly one registered response strobe.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid_i / req_ready_o request handshake
//   req_addr_i, req_data_i    byte address, store data
//   req_we_i, req_funct3_i    1 = store, RISC-V load/store funct3
//   resp_valid_o              one-cycle response strobe
//   resp_data_o               load result (0 for stores and errors)
//   resp_misaligned_o         request was split into byte beats
//   resp_err_o                illegal funct3, no memory access made
//   mem_addr_o, mem_data_o    memory address / write data
//   mem_read_en_o, mem_write_en_o, mem_funct3_o  memory controls
//   mem_data_i                memory read data (combinational, pre-extended)
module lsu_ctrl #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [AWIDTH-1:0] req_addr_i,
   input  logic [DWIDTH-1:0] req_data_i,
   input  logic              req_we_i,
   input  logic [2:0]        req_funct3_i,
   output logic              resp_valid_o,
   output logic [DWIDTH-1:0] resp_data_o,
   output logic              resp_misaligned_o,
   output logic              resp_err_o,
   output logic [AWIDTH-1:0] mem_addr_o,
   output logic [DWIDTH-1:0] mem_data_o,
   output logic              mem_read_en_o,
   output logic              mem_write_en_o,
   output logic [2:0]        mem_funct3_o,
   input  logic [DWIDTH-1:0] mem_data_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, SPLIT = 2'd2, RESP = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] data_q, data_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        beat_q, beat_d;
   logic [DWIDTH-1:0] result_q, result_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DWIDTH-1:0] resp_data_q, resp_data_d;
   logic              resp_mis_q, resp_mis_d;
   logic              resp_err_q, resp_err_d;

   logic              accept;
   logic              req_legal;
   logic              req_aligned;
   logic              last_beat;
   logic [DWIDTH-1:0] assembled;
   logic [DWIDTH-1:0] extended;

   assign req_ready_o = (state_q == IDLE) && !rst;
   assign accept      = req_valid_i && req_ready_o;

   // Legality and alignment are judged on the live request, at acceptance.
   always_comb begin
      req_legal = 1'b0;
      case (req_funct3_i)
         3'b000, 3'b001, 3'b010: req_legal = 1'b1;
         3'b100, 3'b101:         req_legal = !req_we_i;  // LBU/LHU have no store form
         default:                req_legal = 1'b0;
      endcase
      req_aligned = 1'b1;
      case (req_funct3_i[1:0])
         2'b01:   req_aligned = !req_addr_i[0];
         2'b10:   req_aligned = (req_addr_i[1:0] == 2'b00);
         default: req_aligned = 1'b1;
      endcase
   end

   // Only halfword and word requests ever reach SPLIT.
   assign last_beat = (funct3_q[1:0] == 2'b01) ? (beat_q == 2'd1) : (beat_q == 2'd3);

   // Drop the current beat's byte into its lane of the result.
   genvar gi;
   generate
      for (gi = 0; gi < DWIDTH / 8; gi++) begin : g_lane
         assign assembled[8*gi +: 8] = (beat_q == 2'(gi)) ? mem_data_i[7:0]
                                                          : result_q[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      case (funct3_q)
         3'b001:  extended = {{(DWIDTH-16){assembled[15]}}, assembled[15:0]};
         3'b101:  extended = {{(DWIDTH-16){1'b0}}, assembled[15:0]};
         default: extended = assembled;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      data_d       = data_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      beat_d       = beat_q;
      result_d     = result_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_mis_d   = 1'b0;
      resp_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d   = req_addr_i;
               data_d   = req_data_i;
               we_d     = req_we_i;
               funct3_d = req_funct3_i;
               beat_d   = 2'd0;
               result_d = '0;
               if (!req_legal) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_aligned) begin
                  state_d = ACCESS;
               end else begin
                  state_d = SPLIT;
               end
            end
         end
         ACCESS: begin
            if (!we_q) begin
               result_d    = mem_data_i;
               resp_data_d = mem_data_i;
            end
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         SPLIT: begin
            if (!we_q) begin
               result_d = assembled;
            end
            beat_d = beat_q + 2'd1;
            if (last_beat) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_mis_d   = 1'b1;
               resp_data_d  = we_q ? '0 : extended;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory controls decode the registered state, so an asynchronous reset
   // drops every enable immediately.
   always_comb begin
      mem_addr_o     = '0;
      mem_data_o     = '0;
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_funct3_o   = 3'b000;
      case (state_q)
         ACCESS: begin
            mem_addr_o     = addr_q;
            mem_funct3_o   = funct3_q;
            mem_read_en_o  = !we_q;
            mem_write_en_o = we_q;
            mem_data_o     = we_q ? data_q : '0;
         end
         SPLIT: begin
            mem_addr_o     = addr_q + AWIDTH'(beat_q);
            mem_funct3_o   = we_q ? 3'b000 : 3'b100;
            mem_read_en_o  = !we_q;
            mem_write_en_o = we_q;
            mem_data_o     = we_q ? (data_q >> {beat_q, 3'b000}) : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         beat_q       <= 2'd0;
         result_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_mis_q   <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         beat_q       <= beat_d;
         result_q     <= result_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_mis_q   <= resp_mis_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign resp_valid_o      = resp_valid_q;
   assign resp_data_o       = resp_data_q;
   assign resp_misaligned_o = resp_mis_q;
   assign resp_err_o        = resp_err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- directed bench for lsu_ctrl with a behavioural byte memory
// (256 bytes at 0x01000000, 0xDEADBEEF elsewhere) and a response scoreboard.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] req_addr_i;
   logic [31:0] req_data_i;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic        resp_valid_o;
   logic [31:0] resp_data_o;
   logic        resp_misaligned_o;
   logic        resp_err_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_read_en_o;
   logic        mem_write_en_o;
   logic [2:0]  mem_funct3_o;
   logic [31:0] mem_data_i;

   always #5 clk = ~clk;

   lsu_ctrl #(.AWIDTH(32), .DWIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid_i      (req_valid_i),
      .req_ready_o      (req_ready_o),
      .req_addr_i       (req_addr_i),
      .req_data_i       (req_data_i),
      .req_we_i         (req_we_i),
      .req_funct3_i     (req_funct3_i),
      .resp_valid_o     (resp_valid_o),
      .resp_data_o      (resp_data_o),
      .resp_misaligned_o(resp_misaligned_o),
      .resp_err_o       (resp_err_o),
      .mem_addr_o       (mem_addr_o),
      .mem_data_o       (mem_data_o),
      .mem_read_en_o    (mem_read_en_o),
      .mem_write_en_o   (mem_write_en_o),
      .mem_funct3_o     (mem_funct3_o),
      .mem_data_i       (mem_data_i)
   );

   // ---------------- memory model ----------------
   logic [7:0]  mem [0:255];
   logic        mem_clr;
   logic [7:0]  ai;
   logic [31:0] mem_word;
   logic        in_rng;

   always_comb begin
      ai       = mem_addr_o[7:0];
      in_rng   = (mem_addr_o[31:8] == 24'h010000);
      mem_word = {mem[ai + 8'd3], mem[ai + 8'd2], mem[ai + 8'd1], mem[ai]};
      if (!in_rng) mem_data_i = 32'hDEADBEEF;
      else begin
         case (mem_funct3_o)
            3'b000:  mem_data_i = {{24{mem_word[7]}}, mem_word[7:0]};
            3'b001:  mem_data_i = {{16{mem_word[15]}}, mem_word[15:0]};
            3'b100:  mem_data_i = {24'h0, mem_word[7:0]};
            3'b101:  mem_data_i = {16'h0, mem_word[15:0]};
            default: mem_data_i = mem_word;
         endcase
      end
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      end else if (mem_write_en_o && in_rng) begin
         mem[ai] <= mem_data_o[7:0];
         if (mem_funct3_o == 3'b001 || mem_funct3_o == 3'b010) mem[ai + 8'd1] <= mem_data_o[15:8];
         if (mem_funct3_o == 3'b010) begin
            mem[ai + 8'd2] <= mem_data_o[23:16];
            mem[ai + 8'd3] <= mem_data_o[31:24];
         end
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        mis;
      logic        err;
      int          lat;
      int          rd;
      int          wr;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] addr_log[$];
   logic [31:0] dat_log[$];
   logic [2:0]  f3_log[$];

   // Issue one request, watch the memory bus every cycle, compare the response
   // against the scoreboard entry pushed at issue time.
   task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic we, input logic [2:0] f3,
                         input logic [31:0] e_data, input logic e_mis, input logic e_err,
                         input int e_lat, input int e_rd, input int e_wr);
      exp_t e;
      exp_t got;
      int   cyc, rd_cnt, wr_cnt, first_en, waitc;
      logic seen;
      e.data = e_data; e.mis = e_mis; e.err = e_err; e.lat = e_lat; e.rd = e_rd; e.wr = e_wr;
      sb_q.push_back(e);
      addr_log.delete(); dat_log.delete(); f3_log.delete();
      waitc = 0;
      while (!req_ready_o && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      chk({tag, " ready"}, 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_addr_i   = a;
      req_data_i   = d;
      req_we_i     = we;
      req_funct3_i = f3;
      @(posedge clk);
      @(negedge clk);
      // Scramble the request lines: the unit must work from latched values.
      req_valid_i  = 1'b0;
      req_addr_i   = $urandom;
      req_data_i   = $urandom;
      req_we_i     = ~we;
      req_funct3_i = 3'($urandom);
      cyc = 1; rd_cnt = 0; wr_cnt = 0; first_en = 0; seen = 1'b0;
      while (cyc <= 20 && !seen) begin
         if (mem_read_en_o || mem_write_en_o) begin
            if (first_en == 0) first_en = cyc;
            addr_log.push_back(mem_addr_o);
            dat_log.push_back(mem_data_o);
            f3_log.push_back(mem_funct3_o);
         end
         rd_cnt += int'(mem_read_en_o);
         wr_cnt += int'(mem_write_en_o);
         chk({tag, " busy_ready"}, 32'(req_ready_o), 32'd0);
         if (resp_valid_o) seen = 1'b1;
         else begin
            chk({tag, " resp_idle"}, resp_data_o | {30'b0, resp_misaligned_o, resp_err_o}, 32'd0);
            @(negedge clk);
            cyc++;
         end
      end
      chk({tag, " resp_seen"}, 32'(seen), 32'd1);
      got = sb_q.pop_front();
      chk({tag, " data"}, resp_data_o, got.data);
      chk({tag, " misaligned"}, 32'(resp_misaligned_o), 32'(got.mis));
      chk({tag, " err"}, 32'(resp_err_o), 32'(got.err));
      chk({tag, " latency"}, cyc, got.lat);
      chk({tag, " rd_pulses"}, rd_cnt, got.rd);
      chk({tag, " wr_pulses"}, wr_cnt, got.wr);
      chk({tag, " first_en_cycle"}, first_en, (got.rd + got.wr > 0) ? 1 : 0);
      @(negedge clk);
      chk({tag, " resp_one_cycle"}, 32'(resp_valid_o), 32'd0);
      $display("txn %s addr=%h we=%0d f3=%b data=%h mis=%0d err=%0d lat=%0d",
               tag, a, we, f3, resp_data_o, got.mis, got.err, cyc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          wr_b;
      logic [31:0] word;
      rst          = 1'b1;
      mem_clr      = 1'b1;
      req_valid_i  = 1'b0;
      req_addr_i   = '0;
      req_data_i   = '0;
      req_we_i     = 1'b0;
      req_funct3_i = 3'b000;
      repeat (3) @(negedge clk);
      chk("reset ready", 32'(req_ready_o), 32'd0);
      chk("reset resp_valid", 32'(resp_valid_o), 32'd0);
      chk("reset resp_data", resp_data_o, 32'd0);
      chk("reset enables", {30'b0, mem_read_en_o, mem_write_en_o}, 32'd0);
      chk("reset mem_addr", mem_addr_o, 32'd0);
      chk("reset mem_data", mem_data_o, 32'd0);
      rst     = 1'b0;
      mem_clr = 1'b0;
      #1;
      chk("release ready", 32'(req_ready_o), 32'd1);
      @(negedge clk);

      // aligned word store then load
      do_req("sw_al",  32'h01000000, 32'h12345678, 1'b1, 3'b010, 32'h0, 1'b0, 1'b0, 2, 0, 1);
      do_req("lw_al",  32'h01000000, 32'h0,        1'b0, 3'b010, 32'h12345678, 1'b0, 1'b0, 2, 1, 0);

      // misaligned word store: four SB beats
      do_req("sw_mis", 32'h01000005, 32'hAABBCCDD, 1'b1, 3'b010, 32'h0, 1'b1, 1'b0, 5, 0, 4);
      word = 32'hAABBCCDD;
      for (int k = 0; k < 4; k++) begin
         chk("sw_mis beat_addr", addr_log[k], 32'h01000005 + 32'(k));
         chk("sw_mis beat_byte", {24'h0, dat_log[k][7:0]}, {24'h0, 8'(word >> (8 * k))});
         chk("sw_mis beat_f3", {29'h0, f3_log[k]}, 32'd0);
      end
      do_req("lw_mis", 32'h01000005, 32'h0, 1'b0, 3'b010, 32'hAABBCCDD, 1'b1, 1'b0, 5, 4, 0);

      // byte stores then misaligned halfword loads
      do_req("sb_80",  32'h01000003, 32'h12345680, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0, 2, 0, 1);
      do_req("sb_ff",  32'h01000004, 32'h000000FF, 1'b1, 3'b000, 32'h0, 1'b0, 1'b0, 2, 0, 1);
      do_req("lh_mis", 32'h01000003, 32'h0, 1'b0, 3'b001, 32'hFFFFFF80, 1'b1, 1'b0, 3, 2, 0);
      chk("lh_mis beat0_f3", {29'h0, f3_log[0]}, 32'd4);
      chk("lh_mis beat1_addr", addr_log[1], 32'h01000004);
      do_req("lhu_mis", 32'h01000003, 32'h0, 1'b0, 3'b101, 32'h0000FF80, 1'b1, 1'b0, 3, 2, 0);
      do_req("lb",     32'h01000003, 32'h0, 1'b0, 3'b000, 32'hFFFFFF80, 1'b0, 1'b0, 2, 1, 0);
      do_req("lbu",    32'h01000003, 32'h0, 1'b0, 3'b100, 32'h00000080, 1'b0, 1'b0, 2, 1, 0);

      // aligned halfword store/load
      do_req("sh_al",  32'h01000020, 32'h5555BEEF, 1'b1, 3'b001, 32'h0, 1'b0, 1'b0, 2, 0, 1);
      do_req("lh_al",  32'h01000020, 32'h0, 1'b0, 3'b001, 32'hFFFFBEEF, 1'b0, 1'b0, 2, 1, 0);

      // illegal funct3
      do_req("ill_ld", 32'h01000000, 32'h0, 1'b0, 3'b011, 32'h0, 1'b0, 1'b1, 1, 0, 0);
      do_req("ill_st", 32'h01000000, 32'h1, 1'b1, 3'b100, 32'h0, 1'b0, 1'b1, 1, 0, 0);

      // address wrap, out-of-range data passed through per beat
      do_req("lh_wrap", 32'hFFFFFFFF, 32'h0, 1'b0, 3'b001, 32'hFFFFEFEF, 1'b1, 1'b0, 3, 2, 0);
      chk("lh_wrap beat0_addr", addr_log[0], 32'hFFFFFFFF);
      chk("lh_wrap beat1_addr", addr_log[1], 32'h00000000);

      // back-to-back aligned stores with valid held high
      wr_b         = 0;
      req_valid_i  = 1'b1;
      req_addr_i   = 32'h01000040;
      req_data_i   = 32'h11111111;
      req_we_i     = 1'b1;
      req_funct3_i = 3'b010;
      chk("b2b ready_c0", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      @(negedge clk);
      wr_b += int'(mem_write_en_o);
      chk("b2b ready_c1", 32'(req_ready_o), 32'd0);
      req_addr_i = 32'h01000044;
      req_data_i = 32'h22222222;
      @(negedge clk);
      wr_b += int'(mem_write_en_o);
      chk("b2b ready_c2", 32'(req_ready_o), 32'd0);
      chk("b2b resp_c2", 32'(resp_valid_o), 32'd1);
      @(negedge clk);
      wr_b += int'(mem_write_en_o);
      chk("b2b ready_c3", 32'(req_ready_o), 32'd1);
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      wr_b += int'(mem_write_en_o);
      chk("b2b ready_c4", 32'(req_ready_o), 32'd0);
      @(negedge clk);
      wr_b += int'(mem_write_en_o);
      chk("b2b resp_c5", 32'(resp_valid_o), 32'd1);
      @(negedge clk);
      wr_b += int'(mem_write_en_o);
      chk("b2b wr_pulses", wr_b, 2);
      $display("txn b2b two SW wr_pulses=%0d", wr_b);
      do_req("lw_b2b0", 32'h01000040, 32'h0, 1'b0, 3'b010, 32'h11111111, 1'b0, 1'b0, 2, 1, 0);
      do_req("lw_b2b1", 32'h01000044, 32'h0, 1'b0, 3'b010, 32'h22222222, 1'b0, 1'b0, 2, 1, 0);

      // reset during beat 2 of a misaligned word store
      req_valid_i  = 1'b1;
      req_addr_i   = 32'h01000011;
      req_data_i   = 32'h11223344;
      req_we_i     = 1'b1;
      req_funct3_i = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("rst_mid beat0_addr", mem_addr_o, 32'h01000011);
      @(negedge clk);
      chk("rst_mid beat1_addr", mem_addr_o, 32'h01000012);
      @(negedge clk);
      chk("rst_mid beat2_addr", mem_addr_o, 32'h01000013);
      chk("rst_mid beat2_we", 32'(mem_write_en_o), 32'd1);
      chk("rst_mid beat2_byte", {24'h0, mem_data_o[7:0]}, 32'h22);
      rst = 1'b1;
      #1;
      chk("rst_mid enables", {30'b0, mem_read_en_o, mem_write_en_o}, 32'd0);
      chk("rst_mid mem_addr", mem_addr_o, 32'd0);
      chk("rst_mid ready", 32'(req_ready_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid no_resp0", 32'(resp_valid_o), 32'd0);
      @(negedge clk);
      chk("rst_mid ready_after", 32'(req_ready_o), 32'd1);
      chk("rst_mid no_resp1", 32'(resp_valid_o), 32'd0);
      $display("txn rst_mid SW aborted at beat 2");
      do_req("lw_after_rst", 32'h01000011, 32'h0, 1'b0, 3'b010, 32'h00003344, 1'b1, 1'b0, 5, 4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
